// File: rtl/cpu_oam_dma.sv
// Sprite DMA engine on the CPU bus: a write of page P to $4014 pauses the CPU and copies $PP00..$PPFF to OAMDATA.
// Optional get/put alignment (extra dummy read on odd-parity triggers) is enabled by CPU_OAM_DMA_ODD_ALIGN_EN.
module cpu_oam_dma #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter logic [15:0] OAM_ADDR  = 16'h2004
) (
  input  logic        i_CLK,
  input  logic        i_RST_N,
  input  logic [15:0] i_CPU_ADDR,
  input  logic [7:0]  i_CPU_DATA,
  input  logic        i_CPU_R_WN,
  input  logic [7:0]  i_BUS_DATA,
  output logic        o_PAUSE,
  output logic [15:0] o_DMA_ADDR,
  output logic [7:0]  o_DMA_DATA,
  output logic        o_DMA_R_WN,
  output logic        o_DONE,
  output logic [2:0]  o_DBG_STATE
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    EXTRA = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] data_q;
  logic       done_q;
  logic       trigger;
  logic       last;
  logic       odd_start;

  // Handshake: none; the CPU side is snooped and the bus is owned whenever o_PAUSE is high.
  assign trigger = (state == IDLE) && (i_CPU_ADDR == TRIG_ADDR) && !i_CPU_R_WN;
  assign last    = (state == WRITE) && (idx == 8'hFF);

`ifdef CPU_OAM_DMA_ODD_ALIGN_EN
  logic parity;
  logic odd_q;

  // Free-running get/put phase; captured at the trigger edge to decide on the extra cycle.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      parity <= 1'b0;
      odd_q  <= 1'b0;
    end else begin
      parity <= ~parity;
      if (trigger) odd_q <= parity;
    end
  end

  assign odd_start = odd_q;
`else
  assign odd_start = 1'b0;
`endif

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trigger) state_nxt = ALIGN;
      ALIGN:   state_nxt = odd_start ? EXTRA : READ;
      EXTRA:   state_nxt = READ;
      READ:    state_nxt = WRITE;
      WRITE:   state_nxt = last ? IDLE : READ;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      page   <= 8'h00;
      idx    <= 8'h00;
      data_q <= 8'h00;
      done_q <= 1'b0;
    end else begin
      done_q <= last;
      if (trigger) begin
        page <= i_CPU_DATA;
        idx  <= 8'h00;
      end
      if (state == READ) data_q <= i_BUS_DATA;
      // idx stays 8 bits so the source never carries into the page.
      if (state == WRITE && !last) idx <= idx + 8'd1;
    end
  end

  always_comb begin
    o_DMA_ADDR = 16'h0000;
    o_DMA_DATA = 8'h00;
    o_DMA_R_WN = 1'b1;
    case (state)
      ALIGN, EXTRA, READ: o_DMA_ADDR = {page, idx};
      WRITE: begin
        o_DMA_ADDR = OAM_ADDR;
        o_DMA_DATA = data_q;
        o_DMA_R_WN = 1'b0;
      end
      default: ;
    endcase
  end

  assign o_PAUSE     = (state != IDLE);
  assign o_DONE      = done_q;
  assign o_DBG_STATE = state;

endmodule

// File: tb/tb_cpu_oam_dma.sv
// Directed bench for cpu_oam_dma: reset, non-trigger write, full transfers, alignment, page $FF, ignored trigger, abort.
module tb_cpu_oam_dma;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_data = 8'h00;
  logic        cpu_r_wn = 1'b1;
  logic [7:0]  bus_data;
  logic        pause;
  logic [15:0] dma_addr;
  logic [7:0]  dma_data;
  logic        dma_r_wn;
  logic        done;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc;

  int r_len, r_writes, r_bad, r_bad_rd, r_dones, r_pre_reads;
  logic [15:0] r_last_rd;
  int post_writes, post_dones;

  cpu_oam_dma dut (
    .i_CLK      (clk),
    .i_RST_N    (rst_n),
    .i_CPU_ADDR (cpu_addr),
    .i_CPU_DATA (cpu_data),
    .i_CPU_R_WN (cpu_r_wn),
    .i_BUS_DATA (bus_data),
    .o_PAUSE    (pause),
    .o_DMA_ADDR (dma_addr),
    .o_DMA_DATA (dma_data),
    .o_DMA_R_WN (dma_r_wn),
    .o_DONE     (done),
    .o_DBG_STATE(dbg_state)
  );

  always #5 clk = ~clk;

  // Edges since reset release; its LSB is the parity seen at the next posedge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Memory model: byte at $PPii is ii ^ $5A ^ PP ^ $02 (so page $02 holds i ^ $5A).
  assign bus_data = dma_addr[7:0] ^ 8'h5A ^ dma_addr[15:8] ^ 8'h02;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_trigger(input logic [7:0] page, input int want_par);
    @(negedge clk);
    while ((cyc % 2) != want_par) @(negedge clk);
    cpu_addr = 16'h4014;
    cpu_data = page;
    cpu_r_wn = 1'b0;
    @(negedge clk);
    cpu_addr = 16'h0000;
    cpu_data = 8'h00;
    cpu_r_wn = 1'b1;
  endtask

  // Called at the first negedge after the trigger edge; walks the paused window.
  task automatic run_xfer(input logic [7:0] page, input int abort_at, input bit inject);
    int n;
    logic [7:0] exp;
    bit aborted;
    r_len = 0; r_writes = 0; r_bad = 0; r_bad_rd = 0; r_dones = 0; r_pre_reads = 0;
    r_last_rd = 16'h0000;
    n = 0;
    aborted = 1'b0;
    while (pause === 1'b1 && n < 600) begin
      r_len++;
      if (done === 1'b1) r_dones++;
      if (dma_r_wn === 1'b0) begin
        exp = r_writes[7:0] ^ 8'h5A ^ page ^ 8'h02;
        if (dma_addr !== 16'h2004 || dma_data !== exp) r_bad++;
        r_writes++;
      end else begin
        if (r_writes == 0) r_pre_reads++;
        if (dma_addr !== {page, r_writes[7:0]}) r_bad_rd++;
        r_last_rd = dma_addr;
      end
      if (abort_at != 0 && r_writes == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_pause", pause, 1'b0);
        chk("abort_r_wn", dma_r_wn, 1'b1);
        aborted = 1'b1;
        break;
      end
      if (inject && n == 50) begin
        cpu_addr = 16'h4014; cpu_data = 8'h33; cpu_r_wn = 1'b0;
      end
      if (inject && n == 51) begin
        cpu_addr = 16'h0000; cpu_data = 8'h00; cpu_r_wn = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    if (!aborted) begin
      chk("done_after_pause", done, 1'b1);
      if (done === 1'b1) r_dones++;
      repeat (3) begin
        @(negedge clk);
        if (done === 1'b1) r_dones++;
      end
    end
  endtask

  initial begin
    int exp_len, exp_pre;
    #2;
    chk("rst_pause", pause, 1'b0);
    chk("rst_r_wn", dma_r_wn, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_addr", dma_addr, 16'h0000);
    chk("rst_state", dbg_state, 3'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Write to $4015 must not start anything.
    @(negedge clk);
    cpu_addr = 16'h4015; cpu_data = 8'h02; cpu_r_wn = 1'b0;
    @(negedge clk);
    cpu_addr = 16'h0000; cpu_data = 8'h00; cpu_r_wn = 1'b1;
    chk("no_trig_pause", pause, 1'b0);
    @(negedge clk);
    chk("no_trig_state", dbg_state, 3'd0);

    // Page $02, even parity.
    do_trigger(8'h02, 0);
    run_xfer(8'h02, 0, 1'b0);
    chk("p02_len", r_len, 513);
    chk("p02_writes", r_writes, 256);
    chk("p02_bad_data", r_bad, 0);
    chk("p02_bad_rd", r_bad_rd, 0);
    chk("p02_dones", r_dones, 1);
    chk("p02_pre_reads", r_pre_reads, 2);
    chk("p02_last_rd", r_last_rd, 16'h02FF);
    chk("p02_idle", pause, 1'b0);

    // Odd parity trigger.
`ifdef CPU_OAM_DMA_ODD_ALIGN_EN
    exp_len = 514; exp_pre = 3;
`else
    exp_len = 513; exp_pre = 2;
`endif
    do_trigger(8'h03, 1);
    run_xfer(8'h03, 0, 1'b0);
    chk("odd_len", r_len, exp_len);
    chk("odd_pre_reads", r_pre_reads, exp_pre);
    chk("odd_writes", r_writes, 256);
    chk("odd_bad_data", r_bad, 0);
    chk("odd_dones", r_dones, 1);

    // Page $FF: no carry into page on the last read.
    do_trigger(8'hFF, 0);
    run_xfer(8'hFF, 0, 1'b0);
    chk("pff_len", r_len, 513);
    chk("pff_last_rd", r_last_rd, 16'hFFFF);
    chk("pff_bad_rd", r_bad_rd, 0);
    chk("pff_bad_data", r_bad, 0);

    // $4014 write during a transfer is ignored.
    do_trigger(8'h10, 0);
    run_xfer(8'h10, 0, 1'b1);
    chk("inj_len", r_len, 513);
    chk("inj_writes", r_writes, 256);
    chk("inj_bad_data", r_bad, 0);
    chk("inj_bad_rd", r_bad_rd, 0);
    chk("inj_dones", r_dones, 1);

    // Reset at write #100.
    do_trigger(8'h04, 0);
    run_xfer(8'h04, 100, 1'b0);
    chk("abort_writes", r_writes, 100);
    post_writes = 0; post_dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (dma_r_wn === 1'b0) post_writes++;
      if (done === 1'b1) post_dones++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (dma_r_wn === 1'b0) post_writes++;
      if (done === 1'b1) post_dones++;
    end
    chk("abort_post_writes", post_writes, 0);
    chk("abort_post_dones", post_dones, 0);
    chk("abort_pause_after", pause, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
